// File: rtl/addr_gen_2d.sv
// ============================================================================
// addr_gen_2d : nested image-group x library-vector address generator
// Rev 1.0
// ============================================================================
`default_nettype none

module addr_gen_2d #(
  parameter int IMG_VEC_MAX = 10,
  parameter int LIB_VEC_MAX = 6,
  parameter int NCH         = 4,
  localparam int IAW = (IMG_VEC_MAX > 1) ? $clog2(IMG_VEC_MAX) : 1,
  localparam int LAW = (LIB_VEC_MAX > 1) ? $clog2(LIB_VEC_MAX) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [IAW:0]   cfg_img_num_i,
  input  logic [LAW:0]   cfg_lib_num_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [LAW-1:0] lib_addr_o,
  output logic [IAW-1:0] img_base_o,
  output logic [NCH-1:0] img_mask_o,
  output logic           row_last_o,
  output logic           job_last_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           aborted_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [LAW-1:0] lib_addr_q, lib_addr_d;
  logic [IAW-1:0] img_base_q, img_base_d;
  logic [IAW:0]   img_num_q, img_num_d;
  logic [LAW:0]   lib_num_q, lib_num_d;
  logic           done_q, done_d;
  logic           aborted_q, aborted_d;

  logic           w_run;
  logic           w_xfer;
  logic           w_row_last;
  logic           w_job_last;
  logic [IAW:0]   w_base_next;
  logic [NCH-1:0] w_mask;

  assign w_run       = (state_q == S_RUN);
  assign w_xfer      = w_run && out_ready_i;
  assign w_row_last  = w_run && ({1'b0, lib_addr_q} == (lib_num_q - 1'b1));
  // Compared at 32 bits so base+NCH cannot wrap when NCH exceeds the base width.
  assign w_job_last  = w_row_last &&
                       ((32'(img_base_q) + 32'(NCH)) >= 32'(img_num_q));
  assign w_base_next = {1'b0, img_base_q} + (IAW+1)'(NCH);

  for (genvar k = 0; k < NCH; k++) begin : g_mask
    assign w_mask[k] = w_run && ((32'(img_base_q) + 32'(k)) < 32'(img_num_q));
  end

  always_comb begin
    state_d    = state_q;
    lib_addr_d = lib_addr_q;
    img_base_d = img_base_q;
    img_num_d  = img_num_q;
    lib_num_d  = lib_num_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    if (abort_i) begin
      state_d    = S_IDLE;
      lib_addr_d = '0;
      img_base_d = '0;
      done_d     = w_run;
      aborted_d  = w_run;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            img_num_d  = cfg_img_num_i;
            lib_num_d  = cfg_lib_num_i;
            lib_addr_d = '0;
            img_base_d = '0;
            if ((cfg_img_num_i == '0) || (cfg_lib_num_i == '0)) begin
              done_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (w_job_last) begin
              state_d    = S_IDLE;
              lib_addr_d = '0;
              img_base_d = '0;
              done_d     = 1'b1;
            end else if (w_row_last) begin
              lib_addr_d = '0;
              img_base_d = w_base_next[IAW-1:0];
            end else begin
              lib_addr_d = lib_addr_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lib_addr_q <= '0;
      img_base_q <= '0;
      img_num_q  <= '0;
      lib_num_q  <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lib_addr_q <= lib_addr_d;
      img_base_q <= img_base_d;
      img_num_q  <= img_num_d;
      lib_num_q  <= lib_num_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign out_valid_o = w_run;
  assign busy_o      = w_run;
  assign lib_addr_o  = lib_addr_q;
  assign img_base_o  = img_base_q;
  assign img_mask_o  = w_mask;
  assign row_last_o  = w_row_last;
  assign job_last_o  = w_job_last;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_addr_gen_2d.sv
// ============================================================================
// tb_addr_gen_2d : randomized bench for addr_gen_2d against a beat-list model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_addr_gen_2d;

  localparam int IMG_VEC_MAX = 10;
  localparam int LIB_VEC_MAX = 6;
  localparam int NCH         = 4;
  localparam int IAW = (IMG_VEC_MAX > 1) ? $clog2(IMG_VEC_MAX) : 1;
  localparam int LAW = (LIB_VEC_MAX > 1) ? $clog2(LIB_VEC_MAX) : 1;

  logic           clk;
  logic           rst_n;
  logic           start_i;
  logic           abort_i;
  logic [IAW:0]   cfg_img_num_i;
  logic [LAW:0]   cfg_lib_num_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [LAW-1:0] lib_addr_o;
  logic [IAW-1:0] img_base_o;
  logic [NCH-1:0] img_mask_o;
  logic           row_last_o;
  logic           job_last_o;
  logic           busy_o;
  logic           done_o;
  logic           aborted_o;

  int n_checks;
  int n_fail;

  typedef struct {
    int lib;
    int base;
    int mask;
    bit rl;
    bit jl;
  } beat_t;

  addr_gen_2d #(
    .IMG_VEC_MAX (IMG_VEC_MAX),
    .LIB_VEC_MAX (LIB_VEC_MAX),
    .NCH         (NCH)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .cfg_img_num_i (cfg_img_num_i),
    .cfg_lib_num_i (cfg_lib_num_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .lib_addr_o    (lib_addr_o),
    .img_base_o    (img_base_o),
    .img_mask_o    (img_mask_o),
    .row_last_o    (row_last_o),
    .job_last_o    (job_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .aborted_o     (aborted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o),      32'd0);
  endtask

  // One cycle after a done pulse: the pulse must be gone and the block idle.
  task automatic idle_chk();
    @(negedge clk);
    check("idle_done", 32'(done_o), 32'd0);
    check_quiet("idle");
  endtask

  // Starts a job at the current negedge and follows it to its done pulse.
  task automatic run_job(input int img, input int lib, input int low_pct,
                         input int abort_at, input bit inject);
    beat_t q[$];
    beat_t b;
    int    ng;
    int    sent;
    int    cyc;
    sent = 0;
    cyc  = 0;
    ng   = (img + NCH - 1) / NCH;
    if (lib > 0) begin
      for (int g = 0; g < ng; g++) begin
        for (int l = 0; l < lib; l++) begin
          b.lib  = l;
          b.base = g * NCH;
          b.mask = 0;
          for (int k = 0; k < NCH; k++)
            if (b.base + k < img) b.mask |= (1 << k);
          b.rl = (l == lib - 1);
          b.jl = b.rl && (g == ng - 1);
          q.push_back(b);
        end
      end
    end

    cfg_img_num_i = (IAW+1)'(img);
    cfg_lib_num_i = (LAW+1)'(lib);
    start_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;

    if (q.size() == 0) begin
      check_quiet("zero");
      check("zero_done",    32'(done_o),    32'd1);
      check("zero_aborted", 32'(aborted_o), 32'd0);
      return;
    end

    while (q.size() > 0 && cyc < 2000) begin
      cyc++;
      start_i = 1'b0;
      b = q[0];
      check("valid",    32'(out_valid_o), 32'd1);
      check("busy",     32'(busy_o),      32'd1);
      check("done_run", 32'(done_o),      32'd0);
      check("lib_addr", 32'(lib_addr_o),  32'(b.lib));
      check("img_base", 32'(img_base_o),  32'(b.base));
      check("img_mask", 32'(img_mask_o),  32'(b.mask));
      check("row_last", 32'(row_last_o),  32'(b.rl));
      check("job_last", 32'(job_last_o),  32'(b.jl));
      if (inject && cyc == 3) begin
        start_i       = 1'b1;
        cfg_img_num_i = (IAW+1)'(1);
        cfg_lib_num_i = (LAW+1)'(1);
      end
      if (abort_at >= 0 && sent == abort_at) begin
        abort_i     = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        check_quiet("abort");
        check("abort_done",    32'(done_o),    32'd1);
        check("abort_aborted", 32'(aborted_o), 32'd1);
        return;
      end
      out_ready_i = ($urandom_range(0, 99) >= low_pct);
      if (out_ready_i) begin
        void'(q.pop_front());
        sent++;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    check("beats_left", 32'(q.size()), 32'd0);
    check_quiet("end");
    check("end_done",    32'(done_o),    32'd1);
    check("end_aborted", 32'(aborted_o), 32'd0);
  endtask

  initial begin
    int img;
    int lib;
    int ab;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    out_ready_i   = 1'b0;
    cfg_img_num_i = '0;
    cfg_lib_num_i = '0;
    repeat (2) @(negedge clk);
    check_quiet("rst");
    check("rst_lib",  32'(lib_addr_o), 32'd0);
    check("rst_base", 32'(img_base_o), 32'd0);
    check("rst_mask", 32'(img_mask_o), 32'd0);
    check("rst_rl",   32'(row_last_o), 32'd0);
    check("rst_jl",   32'(job_last_o), 32'd0);
    check("rst_done", 32'(done_o),     32'd0);
    check("rst_ab",   32'(aborted_o),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(8, 5, 0, -1, 0);   idle_chk();
    run_job(6, 3, 0, -1, 0);   idle_chk();
    run_job(8, 5, 30, -1, 0);
    run_job(6, 3, 30, -1, 0);  idle_chk();
    run_job(0, 4, 0, -1, 0);   idle_chk();
    run_job(5, 0, 0, -1, 0);   idle_chk();
    run_job(8, 5, 0, 3, 0);
    run_job(8, 5, 0, -1, 0);   idle_chk();
    run_job(IMG_VEC_MAX, LIB_VEC_MAX, 30, -1, 1); idle_chk();

    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("idle_abort_done", 32'(done_o), 32'd0);
    check_quiet("idle_abort");

    abort_i       = 1'b1;
    start_i       = 1'b1;
    cfg_img_num_i = (IAW+1)'(8);
    cfg_lib_num_i = (LAW+1)'(5);
    @(negedge clk);
    abort_i = 1'b0;
    start_i = 1'b0;
    check("abst_done", 32'(done_o), 32'd0);
    check_quiet("abst");
    idle_chk();

    start_i     = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("arst");
    check("arst_lib",  32'(lib_addr_o), 32'd0);
    check("arst_base", 32'(img_base_o), 32'd0);
    check("arst_mask", 32'(img_mask_o), 32'd0);
    check("arst_done", 32'(done_o),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk();

    for (int i = 0; i < 14; i++) begin
      img = $urandom_range(0, IMG_VEC_MAX);
      lib = $urandom_range(0, LIB_VEC_MAX);
      ab  = -1;
      if (($urandom_range(0, 3) == 0) && img > 0 && lib > 0)
        ab = $urandom_range(0, ((img + NCH - 1) / NCH) * lib - 1);
      run_job(img, lib, $urandom_range(0, 50), ab, 0);
      idle_chk();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
